// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the register-file sequencer/arbiter.
// The optional round-robin mode is selected with REGFILE_ARB_ROUND_ROBIN_EN.
package regfile_arb_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 2;

    localparam int REQ_CORE  = 0;
    localparam int REQ_DEBUG = 1;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_WRITE,
        S_READ,
        S_RDATA
    } state_e;

endpackage

// File: rtl/regfile_arbiter_rr_arbiter_2.sv
// Two-way grant logic: fixed core priority by default, alternating on ties
// when REGFILE_ARB_ROUND_ROBIN_EN is defined.
module rr_arbiter_2
    import regfile_arb_pkg::*;
(
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
    input  logic       clk,
    input  logic       rst,
    input  logic       advance,
`endif
    input  logic [1:0] valid,
    output logic [1:0] grant
);

`ifdef REGFILE_ARB_ROUND_ROBIN_EN
    logic last_grant_q;
    logic last_grant_d;

    // last_grant_q = 1 means the debug port was served last, so the core wins the next tie.
    always_comb begin
        grant[REQ_CORE]  = valid[REQ_CORE]  & (~valid[REQ_DEBUG] | last_grant_q);
        grant[REQ_DEBUG] = valid[REQ_DEBUG] & (~valid[REQ_CORE]  | ~last_grant_q);
        last_grant_d     = last_grant_q;
        if (advance && (|valid)) begin
            last_grant_d = grant[REQ_DEBUG];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    always_comb begin
        grant[REQ_CORE]  = valid[REQ_CORE];
        grant[REQ_DEBUG] = valid[REQ_DEBUG] & ~valid[REQ_CORE];
    end
`endif

endmodule

// File: rtl/regfile_arbiter.sv
// Sequences core/debug access to the 4x8 register file's read-A and write ports
// and produces its sync_rst. Tie policy set by REGFILE_ARB_ROUND_ROBIN_EN.
module regfile_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              async_rst,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [1:0]        req_we,
    input  logic [ADDR_W-1:0] req_addr_0,
    input  logic [ADDR_W-1:0] req_addr_1,
    input  logic [DATA_W-1:0] req_wdata_0,
    input  logic [DATA_W-1:0] req_wdata_1,
    output logic [1:0]        rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic              rf_sync_rst,
    output logic              rf_read_en_A,
    output logic [ADDR_W-1:0] rf_addr_read_A,
    output logic              rf_write_en,
    output logic [ADDR_W-1:0] rf_addr_write,
    output logic [DATA_W-1:0] rf_data_in,
    input  logic [DATA_W-1:0] rf_data_out_A
);

    // Handshake: a requester holds valid/we/addr/wdata until it sees its ready bit;
    // transfer happens on the edge where valid & ready are both high; responses
    // are single-cycle rsp_valid pulses with no backpressure.

    state_e              state_q, state_d;
    logic                gnt_idx_q, gnt_idx_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                busy_q, busy_d;
    logic                sync_rst_q, sync_rst_d;
    logic                write_en_q, write_en_d;
    logic                read_en_q, read_en_d;
    logic [1:0]          rsp_valid_q, rsp_valid_d;
    logic [1:0]          grant;
    logic                we_sel;

    rr_arbiter_2 u_arb (
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
        .clk     (clk),
        .rst     (async_rst),
        .advance (state_q == S_IDLE),
`endif
        .valid   (req_valid),
        .grant   (grant)
    );

    always_comb begin
        state_d   = state_q;
        gnt_idx_d = gnt_idx_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_sel    = 1'b0;
        case (state_q)
            S_INIT:  state_d = S_IDLE;
            S_IDLE: begin
                if (|grant) begin
                    gnt_idx_d = grant[REQ_DEBUG];
                    if (grant[REQ_DEBUG]) begin
                        addr_d  = req_addr_1;
                        wdata_d = req_wdata_1;
                        we_sel  = req_we[REQ_DEBUG];
                    end else begin
                        addr_d  = req_addr_0;
                        wdata_d = req_wdata_0;
                        we_sel  = req_we[REQ_CORE];
                    end
                    state_d = we_sel ? S_WRITE : S_READ;
                end
            end
            S_WRITE: state_d = S_IDLE;
            S_READ:  state_d = S_RDATA;
            S_RDATA: state_d = S_IDLE;
            default: state_d = S_INIT;
        endcase

        // Strobes are registered from the next state so they line up with it.
        busy_d      = (state_d != S_IDLE);
        sync_rst_d  = (state_d == S_INIT);
        write_en_d  = (state_d == S_WRITE);
        read_en_d   = (state_d == S_READ);
        rsp_valid_d = 2'b00;
        if ((state_d == S_WRITE) || (state_d == S_RDATA)) begin
            rsp_valid_d[gnt_idx_d] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            state_q     <= S_INIT;
            gnt_idx_q   <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            busy_q      <= 1'b1;
            sync_rst_q  <= 1'b1;
            write_en_q  <= 1'b0;
            read_en_q   <= 1'b0;
            rsp_valid_q <= 2'b00;
        end else begin
            state_q     <= state_d;
            gnt_idx_q   <= gnt_idx_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            busy_q      <= busy_d;
            sync_rst_q  <= sync_rst_d;
            write_en_q  <= write_en_d;
            read_en_q   <= read_en_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign req_ready      = (state_q == S_IDLE) ? grant : 2'b00;
    assign rsp_valid      = rsp_valid_q;
    // The register file already registers read-A data, so it is forwarded directly.
    assign rsp_data       = (state_q == S_RDATA) ? rf_data_out_A : '0;
    assign busy           = busy_q;
    assign rf_sync_rst    = sync_rst_q;
    assign rf_read_en_A   = read_en_q;
    assign rf_addr_read_A = addr_q;
    assign rf_write_en    = write_en_q;
    assign rf_addr_write  = addr_q;
    assign rf_data_in     = wdata_q;

endmodule
